shuffle_keymap: RTL and testbench

- Parametrised keypad-to-digit map that scrambles digit placement on a touch keypad at each unlock attempt. Replaces the fixed 10-key display register with generic key count and digit width.
- Adds an internal 16-bit LFSR, a true Fisher-Yates shuffle and a busy/done handshake, so the block no longer needs an external cycle counter.
- Sits between the keypad scanner and the display/password checker.

---
 rtl/shuffle_keymap.sv | 111 +++++++++++
 tb/tb_shuffle_keymap.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_keymap.sv
// Keypad-to-digit map that reshuffles itself using an internal LFSR and a Fisher-Yates shuffle.
// Optional reverse lookup (digit -> key) is enabled with `define SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN.
module shuffle_keymap #(
  parameter  int NUM_KEYS = 10,
  parameter  int DIGIT_W  = 4,
  localparam int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        seed_i,
  input  logic               seed_load_i,
  input  logic               shuffle_start_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic [IDX_W-1:0]   key_index_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               digit_valid_o
`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
  ,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [IDX_W-1:0]   key_index_o,
  output logic               key_index_valid_o
`endif
);

  typedef enum logic {IDLE, SHUFFLE} state_t;

  state_t             state;
  state_t             state_next;
  logic [DIGIT_W-1:0] map [NUM_KEYS];
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [IDX_W-1:0]   i;
  logic [IDX_W-1:0]   j;
  logic [7:0]         modulus;
  logic               done_q;
  logic               start_go;
  logic               last_swap;

  assign start_go  = (state == IDLE) && shuffle_start_i;
  assign last_swap = (state == SHUFFLE) && (i == IDX_W'(1));
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign modulus   = 8'(i) + 8'd1;
  assign j         = IDX_W'(lfsr[7:0] % modulus);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_go)  state_next = SHUFFLE;
      SHUFFLE: if (last_swap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == SHUFFLE);
    done_o = done_q;
  end

  // The LFSR free-runs in every state; a zero seed would lock it up, so it becomes 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= 16'h0001;
      i      <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) map[k] <= DIGIT_W'(k);
    end else begin
      if (seed_load_i) lfsr <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
      else             lfsr <= lfsr_next;
      done_q <= last_swap;
      if (start_go) begin
        i <= IDX_W'(NUM_KEYS - 1);
        for (int k = 0; k < NUM_KEYS; k++) map[k] <= DIGIT_W'(k);
      end else if (state == SHUFFLE) begin
        i <= i - IDX_W'(1);
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (IDX_W'(k) == i)      map[k] <= map[j];
          else if (IDX_W'(k) == j) map[k] <= map[i];
        end
      end
    end
  end

  always_comb begin
    digit_o       = '0;
    digit_valid_o = 1'b0;
    if (32'(key_index_i) < NUM_KEYS) begin
      digit_o       = map[key_index_i];
      digit_valid_o = ~busy_o;
    end
  end

`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
  always_comb begin
    key_index_o       = '0;
    key_index_valid_o = 1'b0;
    if (32'(digit_i) < NUM_KEYS) begin
      key_index_valid_o = ~busy_o;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (map[k] == digit_i) key_index_o = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: tb/tb_shuffle_keymap.sv
// Directed bench for shuffle_keymap: reset map, shuffle latency, ignored restart, mid-shuffle reset, zero seed.
// Define SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN to also exercise the reverse lookup ports.
module tb_shuffle_keymap;

  logic        clk;
  logic        rst;
  logic [15:0] seed_i;
  logic        seed_load_i;
  logic        shuffle_start_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  key_index_i;
  logic [3:0]  digit_o;
  logic        digit_valid_o;
`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
  logic [3:0]  digit_i;
  logic [3:0]  key_index_o;
  logic        key_index_valid_o;
`endif

  int total = 0;
  int bad   = 0;
  int busy_cnt, done_cnt, done_cyc, overlap_cnt, valid_in_busy;
  logic [3:0]  mid_digit;
  logic [3:0]  exp_map   [10];
  logic [3:0]  obs_map   [10];
  logic [3:0]  first_map [10];
  logic [15:0] mask;

  shuffle_keymap #(.NUM_KEYS(10), .DIGIT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .seed_i          (seed_i),
    .seed_load_i     (seed_load_i),
    .shuffle_start_i (shuffle_start_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .key_index_i     (key_index_i),
    .digit_o         (digit_o),
    .digit_valid_o   (digit_valid_o)
`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
    ,
    .digit_i           (digit_i),
    .key_index_o       (key_index_o),
    .key_index_valid_o (key_index_valid_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference: value after load, one step on the start edge, then one swap+step per busy cycle.
  task automatic model_shuffle(input logic [15:0] seed);
    logic [15:0] l;
    logic [3:0]  t;
    int          jj;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int k = 0; k < 10; k++) exp_map[k] = 4'(k);
    l = lfsr_step(l);
    for (int ii = 9; ii >= 1; ii--) begin
      jj = int'(l[7:0]) % (ii + 1);
      t           = exp_map[ii];
      exp_map[ii] = exp_map[jj];
      exp_map[jj] = t;
      l = lfsr_step(l);
    end
  endtask

  task automatic read_map();
    for (int k = 0; k < 10; k++) begin
      key_index_i = 4'(k);
      #1;
      obs_map[k] = digit_o;
    end
  endtask

  task automatic check_map(input string tag);
    mask = '0;
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("%s_key%0d", tag, k), 32'(obs_map[k]), 32'(exp_map[k]));
      mask = mask | (16'h1 << obs_map[k]);
    end
    check_output({tag, "_perm"}, 32'(mask), 32'h03FF);
  endtask

  // Seed load, start one cycle later, then observe busy/done for 14 cycles.
  task automatic apply_stimulus(input logic [15:0] seed, input int restart_at);
    seed_i      = seed;
    seed_load_i = 1'b1;
    tick();
    seed_load_i     = 1'b0;
    shuffle_start_i = 1'b1;
    key_index_i     = 4'd9;
    tick();
    shuffle_start_i = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; overlap_cnt = 0; valid_in_busy = 0;
    mid_digit = '0;
    for (int c = 1; c <= 14; c++) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (busy_o && done_o) overlap_cnt++;
      if (busy_o && digit_valid_o) valid_in_busy++;
      if (c == 2) mid_digit = digit_o;
      shuffle_start_i = (c == restart_at);
      tick();
    end
    shuffle_start_i = 1'b0;
  endtask

  task automatic check_timing(input string tag);
    check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
    check_output({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_output({tag, "_done_cycle"}, 32'(done_cyc), 32'd10);
    check_output({tag, "_busy_done_overlap"}, 32'(overlap_cnt), 32'd0);
    check_output({tag, "_valid_in_busy"}, 32'(valid_in_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; seed_i = '0; seed_load_i = 1'b0; shuffle_start_i = 1'b0; key_index_i = '0;
`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
    digit_i = '0;
`endif
    #12;
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_lfsr", 32'(dut.lfsr), 32'h0001);
    tick();
    rst = 1'b0;

    $display("[TB] identity map after reset");
    for (int k = 0; k < 10; k++) begin
      key_index_i = 4'(k);
      #1;
      check_output($sformatf("id_digit%0d", k), 32'(digit_o), 32'(k));
      check_output($sformatf("id_valid%0d", k), 32'(digit_valid_o), 32'd1);
    end
    key_index_i = 4'd12;
    #1;
    check_output("oor_digit", 32'(digit_o), 32'd0);
    check_output("oor_valid", 32'(digit_valid_o), 32'd0);

    $display("[TB] shuffle with seed ACE1");
    apply_stimulus(16'hACE1, 0);
    check_timing("run1");
    check_output("run1_first_swap", 32'(mid_digit), 32'd5);
    model_shuffle(16'hACE1);
    read_map();
    check_map("run1");
    for (int k = 0; k < 10; k++) first_map[k] = obs_map[k];

    $display("[TB] repeat with same seed");
    apply_stimulus(16'hACE1, 0);
    read_map();
    for (int k = 0; k < 10; k++)
      check_output($sformatf("repeat_key%0d", k), 32'(obs_map[k]), 32'(first_map[k]));

    $display("[TB] restart request during busy cycle 4");
    apply_stimulus(16'hACE1, 4);
    check_timing("restart");
    read_map();
    check_map("restart");

`ifdef SHUFFLE_KEYMAP_REVERSE_LOOKUP_EN
    $display("[TB] reverse lookup");
    for (int d = 0; d < 10; d++) begin
      digit_i = 4'(d);
      #1;
      check_output($sformatf("rev_valid%0d", d), 32'(key_index_valid_o), 32'd1);
      check_output($sformatf("rev_map%0d", d), 32'(obs_map[key_index_o]), 32'(d));
    end
    digit_i = 4'd11;
    #1;
    check_output("rev_oor_valid", 32'(key_index_valid_o), 32'd0);
    check_output("rev_oor_index", 32'(key_index_o), 32'd0);
`endif

    $display("[TB] reset during busy cycle 5");
    seed_i      = 16'hACE1;
    seed_load_i = 1'b1;
    tick();
    seed_load_i     = 1'b0;
    shuffle_start_i = 1'b1;
    tick();
    shuffle_start_i = 1'b0;
    repeat (4) tick();
    check_output("mid_busy_before_rst", 32'(busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy", 32'(busy_o), 32'd0);
    check_output("mid_rst_done", 32'(done_o), 32'd0);
    check_output("mid_rst_lfsr", 32'(dut.lfsr), 32'h0001);
    read_map();
    for (int k = 0; k < 10; k++)
      check_output($sformatf("mid_rst_key%0d", k), 32'(obs_map[k]), 32'(k));
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_o || busy_o) done_cnt++;
      tick();
    end
    check_output("mid_rst_no_done", 32'(done_cnt), 32'd0);

    $display("[TB] zero seed");
    seed_i      = 16'h0000;
    seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    check_output("zero_seed_lfsr", 32'(dut.lfsr), 32'h0001);
    seed_i      = 16'h0000;
    seed_load_i = 1'b1;
    apply_stimulus(16'h0000, 0);
    check_timing("zero");
    check_output("zero_first_swap", 32'(mid_digit), 32'd2);
    model_shuffle(16'h0000);
    read_map();
    check_map("zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
